debug_ocimem_ctrl: RTL and testbench
====================================

DEBUG_OCIMEM_CTRL -- requirements
Module: debug_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the debug RAM (2^ADDR_W x 32-bit words); only 8 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all logic in this domain.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port jdo  in  38  JTAG data word from the debug-slave sysclk stage.
REQ-005 SHALL have ports take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b  in  1 each  one-cycle JTAG command strobes.
REQ-006 SHALL have ports avs_address  in  ADDR_W; avs_read, avs_write, avs_debugaccess  in  1; avs_writedata  in  32; avs_byteenable  in  4  CPU-side slave request.
REQ-007 SHALL have ports avs_readdata  out  32; avs_waitrequest  out  1  CPU-side slave response.
REQ-008 SHALL have ports MonDReg  out  32; monitor_ready, monitor_error  out  1  results returned to the debug-slave tck stage.

Function
REQ-009 SHALL, on take_action_ocimem_a, load MonAReg <= jdo[24:17]; if jdo[35]=1, clear monitor_error in the same cycle.
REQ-010 SHALL, on take_no_action_ocimem_a, queue a JTAG read of RAM[MonAReg].
REQ-011 SHALL, on take_action_ocimem_b, queue a JTAG write of jdo[34:3] to RAM[MonAReg], full word.
REQ-012 SHALL hold one pending JTAG command; a new read/write strobe while one is pending is dropped and sets monitor_error.
REQ-013 SHALL run FSM states IDLE, J_RD, J_CAP, J_WR, A_RD, A_RSP, A_WR.
REQ-014 SHALL, in IDLE, service a pending JTAG command before an Avalon request when both are present (JTAG priority).
REQ-015 SHALL sequence IDLE->J_RD (RAM addressed)->J_CAP (MonDReg <= RAM data, MonAReg+1, monitor_ready<=1)->IDLE.
REQ-016 SHALL sequence IDLE->J_WR (RAM write, MonAReg+1)->IDLE.
REQ-017 SHALL clear monitor_ready when any JTAG command strobe is accepted.
REQ-018 SHALL wrap MonAReg modulo 2^ADDR_W (255+1 -> 0).
REQ-019 SHALL sequence Avalon reads IDLE->A_RD->A_RSP, with avs_readdata valid and avs_waitrequest=0 in A_RSP only; 2-cycle minimum latency.
REQ-020 SHALL sequence Avalon writes IDLE->A_WR, with avs_waitrequest=0 in A_WR only; the RAM write occurs in A_WR.
REQ-021 SHALL assert avs_waitrequest whenever avs_read or avs_write is high outside A_RSP/A_WR.
REQ-022 SHALL complete an Avalon write with avs_debugaccess=0 without modifying RAM and SHALL set monitor_error.
REQ-023 SHALL, when avs_read and avs_write are both high, treat the request as a read.

Reset
REQ-024 SHALL, while reset=1, force FSM=IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, pending JTAG command cleared, avs_readdata=0.
REQ-025 SHALL abandon any in-flight transaction on reset; RAM contents are not cleared and an interrupted write may or may not have landed.

Configuration
REQ-026 SHALL honour avs_byteenable on Avalon writes when OCIMEM_AVS_BYTEEN_EN is defined; without it, avs_byteenable is ignored and every Avalon write is full-word; the port exists in both builds.

Structure
REQ-027 SHALL place ADDR_W default, jdo field positions (address 24:17, data 34:3, clear-error 35) and the FSM state enum in shared package debug_ocimem_pkg.
REQ-028 SHALL instantiate one sub-module, debug_ocimem_ram: single-port synchronous RAM, 1-cycle read, 4-bit byte write enable.

Verification
REQ-029 SHALL cover: take_action_ocimem_a with jdo[24:17]=0x10, then take_action_ocimem_b with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11.
REQ-030 SHALL cover: MonAReg=0xFF, take_no_action_ocimem_a -> MonDReg=RAM[0xFF] two cycles after the strobe, monitor_ready=1, MonAReg=0x00.
REQ-031 SHALL cover: avs_read to address 0x10 in the same cycle as a JTAG write strobe to 0x10 -> JTAG write first, avs_readdata=new value, waitrequest low exactly one cycle.
REQ-032 SHALL cover: second JTAG strobe one cycle after the first -> second dropped, monitor_error=1; take_action_ocimem_a with jdo[35]=1 -> monitor_error=0.
REQ-033 SHALL cover: avs_write 0x11223344, byteenable 4'b0001, debugaccess=1 -> only byte 0 changes with OCIMEM_AVS_BYTEEN_EN, whole word without it; repeat with debugaccess=0 -> RAM unchanged, monitor_error=1.
REQ-034 SHALL cover: reset asserted in A_RD -> all outputs at reset values immediately, FSM IDLE after release, next read completes normally.

Source files
------------

// File: rtl/debug_ocimem_pkg.sv
// ---------------------------------------------------------------------------
// debug_ocimem_pkg
// Shared constants for the on-chip debug memory controller:
//   - default debug-RAM word-address width
//   - field positions inside the 38-bit JTAG data word (jdo)
//   - FSM state encoding
// Optional feature macro used by the controller: OCIMEM_AVS_BYTEEN_EN
// ---------------------------------------------------------------------------
package debug_ocimem_pkg;

    // Debug RAM geometry: 2^ADDR_W words of 32 bits. Only 8 is supported.
    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W         = 32;
    localparam int BE_W           = DATA_W / 8;

    // jdo field positions
    localparam int JDO_W          = 38;
    localparam int JDO_ADDR_LSB   = 17;
    localparam int JDO_ADDR_MSB   = JDO_ADDR_LSB + ADDR_W_DEFAULT - 1;  // 24
    localparam int JDO_DATA_LSB   = 3;
    localparam int JDO_DATA_MSB   = JDO_DATA_LSB + DATA_W - 1;          // 34
    localparam int JDO_CLR_ERR    = 35;

    // FSM state encoding
    typedef logic [2:0] ocimem_state_t;

    localparam ocimem_state_t ST_IDLE  = 3'd0;
    localparam ocimem_state_t ST_J_RD  = 3'd1;  // JTAG read: RAM addressed
    localparam ocimem_state_t ST_J_CAP = 3'd2;  // JTAG read: capture RAM data
    localparam ocimem_state_t ST_J_WR  = 3'd3;  // JTAG write: RAM written
    localparam ocimem_state_t ST_A_RD  = 3'd4;  // Avalon read: RAM addressed
    localparam ocimem_state_t ST_A_RSP = 3'd5;  // Avalon read: data returned
    localparam ocimem_state_t ST_A_WR  = 3'd6;  // Avalon write: RAM written

endpackage

// File: rtl/debug_ocimem_ram.sv
// ---------------------------------------------------------------------------
// debug_ocimem_ram
// Single-port synchronous RAM, one-cycle read latency, per-byte write enable.
// Read returns the old word when reading and writing the same address.
// No reset: contents survive a controller reset.
// Ports:
//   clk    in   clock
//   addr   in   word address
//   be     in   byte write enables (all zero = read only)
//   wdata  in   write data
//   rdata  out  registered read data for the address of the previous cycle
// ---------------------------------------------------------------------------
module debug_ocimem_ram
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// debug_ocimem_ctrl
// Arbitrates a 2^ADDR_W x 32 debug RAM between JTAG commands (from the
// debug-slave sysclk stage) and a CPU-side Avalon-MM slave port.
//
// Optional feature: define OCIMEM_AVS_BYTEEN_EN to honour avs_byteenable on
// Avalon writes. Without it every Avalon write is full-word.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   jdo                        JTAG data word (addr 24:17, data 34:3, clr-err 35)
//   take_action_ocimem_a       load MonAReg (optionally clear monitor_error)
//   take_no_action_ocimem_a    queue JTAG read of RAM[MonAReg]
//   take_action_ocimem_b       queue JTAG write of jdo data to RAM[MonAReg]
//   avs_*                      Avalon-MM slave request / response
//   MonDReg                    last JTAG read data
//   monitor_ready              JTAG read data valid in MonDReg
//   monitor_error              dropped JTAG command or denied Avalon write
//   dbg_state                  current FSM state
//
// Avalon handshake: a request (avs_read or avs_write) is held by the master
// until it samples avs_waitrequest=0 on a rising edge; that edge completes
// the transfer. waitrequest is low only in A_RSP (read data valid on
// avs_readdata) and A_WR (write lands on that edge). Read wins if both
// avs_read and avs_write are high.
// ---------------------------------------------------------------------------
module debug_ocimem_ctrl
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic              avs_debugaccess,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output ocimem_state_t     dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    ocimem_state_t     state;
    ocimem_state_t     state_nxt;
    logic [ADDR_W-1:0] mon_a;
    logic              busy;        // a JTAG command is held or in flight
    logic              busy_write;  // type of the held command
    logic [DATA_W-1:0] cmd_data;

    logic              any_strobe;
    logic              accept;
    logic              drop;
    logic              avs_wr_denied;
    logic              jtag_done;
    logic [BE_W-1:0]   avs_be_eff;

    logic [ADDR_W-1:0] ram_addr;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Bits of jdo that belong to other debug-slave commands.
    logic jdo_unused;
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_CLR_ERR+1], jdo[JDO_DATA_LSB-1:0]};

`ifdef OCIMEM_AVS_BYTEEN_EN
    assign avs_be_eff = avs_byteenable;
`else
    logic byteen_unused;
    assign byteen_unused = ^avs_byteenable;
    assign avs_be_eff    = {BE_W{1'b1}};
`endif

    // A read/write strobe is accepted only when no command is outstanding.
    // The outstanding slot stays occupied until the command finishes in
    // J_CAP / J_WR, so a strobe arriving while one is in flight is dropped.
    // Both strobes at once: the write is taken, the read counts as dropped.
    always_comb begin
        any_strobe    = take_no_action_ocimem_a | take_action_ocimem_b;
        accept        = any_strobe & ~busy;
        drop          = (any_strobe & busy) |
                        (take_no_action_ocimem_a & take_action_ocimem_b);
        avs_wr_denied = (state == ST_A_WR) & ~avs_debugaccess;
        jtag_done     = (state == ST_J_CAP) | (state == ST_J_WR);
    end

    // Next state. In IDLE a JTAG command (held, or arriving this cycle)
    // beats any Avalon request; dispatching the arriving strobe directly
    // saves a cycle of read latency.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (busy) begin
                    state_nxt = busy_write ? ST_J_WR : ST_J_RD;
                end else if (accept) begin
                    state_nxt = take_action_ocimem_b ? ST_J_WR : ST_J_RD;
                end else if (avs_read) begin
                    state_nxt = ST_A_RD;
                end else if (avs_write) begin
                    state_nxt = ST_A_WR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_J_RD:  state_nxt = ST_J_CAP;
            ST_A_RD:  state_nxt = ST_A_RSP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            mon_a         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            busy          <= 1'b0;
            busy_write    <= 1'b0;
            cmd_data      <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                busy       <= 1'b1;
                busy_write <= take_action_ocimem_b;
            end else if (jtag_done) begin
                busy       <= 1'b0;
            end

            if (accept && take_action_ocimem_b) begin
                cmd_data <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            end

            // An explicit address load wins over the post-access increment.
            if (take_action_ocimem_a) begin
                mon_a <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
            end else if (jtag_done) begin
                mon_a <= mon_a + ADDR_ONE;
            end

            if (state == ST_J_CAP) begin
                MonDReg <= ram_rdata;
            end

            if (accept || take_action_ocimem_a) begin
                monitor_ready <= 1'b0;
            end else if (state == ST_J_CAP) begin
                monitor_ready <= 1'b1;
            end

            // A new error event wins over a clear in the same cycle.
            if (drop || avs_wr_denied) begin
                monitor_error <= 1'b1;
            end else if (take_action_ocimem_a && jdo[JDO_CLR_ERR]) begin
                monitor_error <= 1'b0;
            end
        end
    end

    // RAM port steering
    always_comb begin
        ram_addr  = avs_address;
        ram_wdata = avs_writedata;
        ram_be    = '0;
        if ((state == ST_J_RD) || (state == ST_J_WR)) begin
            ram_addr = mon_a;
        end
        if (state == ST_J_WR) begin
            ram_wdata = cmd_data;
            ram_be    = {BE_W{1'b1}};
        end else if ((state == ST_A_WR) && avs_debugaccess) begin
            ram_be    = avs_be_eff;
        end
    end

    debug_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Read data is gated so it is zero outside A_RSP (and hence in reset).
    assign avs_readdata    = (state == ST_A_RSP) ? ram_rdata : '0;
    assign avs_waitrequest = ~((state == ST_A_RSP) || (state == ST_A_WR));
    assign dbg_state       = state;

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debug_ocimem_ctrl
// Directed self-checking bench for debug_ocimem_ctrl. Expected values are
// hand-computed constants; Avalon read expectations go through exp_q.
// ---------------------------------------------------------------------------
module tb_debug_ocimem_ctrl;
    import debug_ocimem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic        avs_debugaccess;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [2:0]  dbg_state;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_debugaccess         (avs_debugaccess),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .dbg_state               (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_set_addr(input logic [7:0] a, input logic clr);
        jdo = '0;
        jdo[24:17] = a;
        jdo[35] = clr;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
    endtask

    task automatic jtag_write_strobe(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
    endtask

    task automatic jtag_read_strobe();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic avs_wr(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic dbg);
        logic done;
        done = 1'b0;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_debugaccess = dbg;
        avs_write = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!avs_waitrequest) done = 1'b1;
            tick();
        end
        avs_write = 1'b0;
        if (!done) check("avs_wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic avs_rd(input logic [7:0] a, output logic [31:0] d, output int waits);
        logic done;
        done = 1'b0;
        waits = 0;
        d = '0;
        avs_address = a;
        avs_read = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!avs_waitrequest) begin
                d = avs_readdata;
                done = 1'b1;
            end else begin
                waits++;
            end
            tick();
        end
        avs_read = 1'b0;
        if (!done) check("avs_rd_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard read: compare against the front of exp_q.
    task automatic avs_rd_check(input string tag, input logic [7:0] a);
        logic [31:0] d;
        int          w;
        logic [31:0] e;
        avs_rd(a, d, w);
        e = exp_q.pop_front();
        check(tag, d, e);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    int          waits;
    logic [31:0] byte_exp;

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_debugaccess = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        repeat (2) tick();

        // Reset state
        check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready",   32'(monitor_ready), 32'd0);
        check("rst_error",   32'(monitor_error), 32'd0);
        check("rst_rdata",   avs_readdata, 32'h0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd1);
        reset = 1'b0;
        tick();

        // Preload through Avalon, full word, debug access
        avs_wr(8'h11, 32'hA5A5_0011, 4'hF, 1'b1);
        avs_wr(8'hFF, 32'hCAFE_00FF, 4'hF, 1'b1);
        avs_wr(8'h00, 32'h1234_0000, 4'hF, 1'b1);
        avs_wr(8'h21, 32'h0000_0000, 4'hF, 1'b1);
        avs_wr(8'h30, 32'hAABB_CCDD, 4'hF, 1'b1);
        check("pre_err", 32'(monitor_error), 32'd0);
        avs_rd(8'h11, rd, waits);
        check("avs_rd_11", rd, 32'hA5A5_0011);
        check("avs_rd_latency", 32'(waits), 32'd2);

        // JTAG write to 0x10, then MonAReg must be 0x11
        jtag_set_addr(8'h10, 1'b0);
        jtag_write_strobe(32'hDEAD_BEEF);
        tick();
        exp_q.push_back(32'hDEAD_BEEF);
        avs_rd_check("jwr_ram10", 8'h10);
        jtag_read_strobe();
        tick();
        check("jrd_ready_early", 32'(monitor_ready), 32'd0);
        tick();
        check("jrd_addr_inc", MonDReg, 32'hA5A5_0011);
        check("jrd_ready", 32'(monitor_ready), 32'd1);

        // JTAG read at 0xFF and wrap to 0x00
        jtag_set_addr(8'hFF, 1'b0);
        check("seta_clr_ready", 32'(monitor_ready), 32'd0);
        jtag_read_strobe();
        tick();
        check("jrd_ff_ready_early", 32'(monitor_ready), 32'd0);
        tick();
        check("jrd_ff_data", MonDReg, 32'hCAFE_00FF);
        check("jrd_ff_ready", 32'(monitor_ready), 32'd1);
        jtag_read_strobe();
        tick();
        tick();
        check("jrd_wrap_data", MonDReg, 32'h1234_0000);

        // JTAG write and Avalon read of the same word in the same cycle
        jtag_set_addr(8'h10, 1'b0);
        jdo = '0;
        jdo[34:3] = 32'h0BAD_F00D;
        take_action_ocimem_b = 1'b1;
        avs_address = 8'h10;
        avs_read = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        check("prio_state", 32'(dbg_state), 32'(ST_J_WR));
        check("prio_waitreq", 32'(avs_waitrequest), 32'd1);
        begin
            logic done;
            done = 1'b0;
            waits = 0;
            rd = '0;
            for (int i = 0; i < 20 && !done; i++) begin
                if (!avs_waitrequest) begin
                    rd = avs_readdata;
                    done = 1'b1;
                end else begin
                    waits++;
                end
                tick();
            end
            avs_read = 1'b0;
            if (!done) check("prio_timeout", 32'd0, 32'd1);
        end
        check("prio_rdata", rd, 32'h0BAD_F00D);
        check("prio_waits", 32'(waits), 32'd3);
        check("prio_wr_one_cycle", 32'(avs_waitrequest), 32'd1);

        // Second strobe one cycle after the first is dropped
        jtag_set_addr(8'h20, 1'b1);
        check("drop_err_pre", 32'(monitor_error), 32'd0);
        jtag_write_strobe(32'h1111_1111);
        jtag_write_strobe(32'h2222_2222);
        check("drop_err", 32'(monitor_error), 32'd1);
        tick();
        exp_q.push_back(32'h1111_1111);
        avs_rd_check("drop_first_kept", 8'h20);
        exp_q.push_back(32'h0000_0000);
        avs_rd_check("drop_second_lost", 8'h21);
        jtag_set_addr(8'h20, 1'b1);
        check("err_clear", 32'(monitor_error), 32'd0);

        // Byte-enable handling and denied write
`ifdef OCIMEM_AVS_BYTEEN_EN
        byte_exp = 32'hAABB_CC44;
`else
        byte_exp = 32'h1122_3344;
`endif
        avs_wr(8'h30, 32'h1122_3344, 4'b0001, 1'b1);
        exp_q.push_back(byte_exp);
        avs_rd_check("byteen_write", 8'h30);
        check("byteen_err", 32'(monitor_error), 32'd0);
        avs_wr(8'h30, 32'h5566_7788, 4'hF, 1'b0);
        exp_q.push_back(byte_exp);
        avs_rd_check("nodbg_unchanged", 8'h30);
        check("nodbg_err", 32'(monitor_error), 32'd1);

        // Reset in the middle of an Avalon read
        jtag_set_addr(8'h10, 1'b0);
        jtag_read_strobe();
        tick();
        tick();
        check("pre_rst_mondreg", MonDReg, 32'h0BAD_F00D);
        check("pre_rst_ready", 32'(monitor_ready), 32'd1);
        avs_address = 8'h10;
        avs_read = 1'b1;
        tick();
        check("pre_rst_state", 32'(dbg_state), 32'(ST_A_RD));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state",   32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_rdata",   avs_readdata, 32'h0);
        check("mid_rst_waitreq", 32'(avs_waitrequest), 32'd1);
        check("mid_rst_mondreg", MonDReg, 32'h0);
        check("mid_rst_ready",   32'(monitor_ready), 32'd0);
        check("mid_rst_error",   32'(monitor_error), 32'd0);
        avs_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        avs_rd(8'h10, rd, waits);
        check("post_rst_read", rd, 32'h0BAD_F00D);
        check("post_rst_latency", 32'(waits), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
